// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM
// state encoding, fault cause codes and the legality/alignment helpers.
package lsu_pkg;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  // Fault cause codes reported to writeback
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // A funct3 is legal for stores only in 000..010; loads reject 011/110/111.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Access size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: picks the byte/halfword addressed by
// addr_lo out of the bus word and sign- or zero-extends it per funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extend according to the load flavour
  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = rdata[16*addr_lo[1] +: 16];
    result   = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = rdata;
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access at a time from execute, checks
// legality/alignment, runs a single word-aligned bus transaction and returns
// a one-cycle response. Optional bus timeout enabled by macro LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [1:0]  resp_cause
);

  // Counter must be able to reach TIMEOUT_CYCLES; reject bad parameter sets.
  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("load_store_unit: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;
  logic [1:0]  resp_cause_q, resp_cause_d;

  logic [31:0] load_data;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic        in_bus;

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  lsu_load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (load_data)
  );

  // Store lane replication and byte strobes from the latched request
  always_comb begin
    store_wdata = wdata_q;
    store_wstrb = 4'b1111;
    case (funct3_q[1:0])
      2'b00: begin
        store_wdata = {4{wdata_q[7:0]}};
        store_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        store_wdata = {2{wdata_q[15:0]}};
        store_wstrb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        store_wdata = wdata_q;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  // Bus and response outputs are decoded from state so reset zeroes them at once
  assign in_bus     = (state_q == ST_BUS);
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = in_bus;
  assign mem_we     = in_bus & is_store_q;
  assign mem_addr   = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = mem_we ? store_wdata : 32'h0;
  assign mem_wstrb  = mem_we ? store_wstrb : 4'b0000;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_valid ? resp_data_q : 32'h0;
  assign resp_fault = resp_valid & resp_fault_q;
  assign resp_cause = resp_valid ? resp_cause_q : CAUSE_NONE;

  // Next-state and next-data logic for the IDLE/BUS/RESP sequence
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    resp_cause_d = resp_cause_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_store_d  = is_store;
          funct3_d    = funct3;
          addr_d      = addr;
          wdata_d     = wdata;
          resp_data_d = 32'h0;
`ifdef LSU_TIMEOUT_EN
          cnt_d       = '0;
`endif
          if (!f3_legal(is_store, funct3)) begin
            state_d      = ST_RESP;
            resp_fault_d = 1'b1;
            resp_cause_d = CAUSE_ILLEGAL;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            state_d      = ST_RESP;
            resp_fault_d = 1'b1;
            resp_cause_d = CAUSE_MISALIGN;
          end else begin
            state_d      = ST_BUS;
            resp_fault_d = 1'b0;
            resp_cause_d = CAUSE_NONE;
          end
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a coincident timeout
        if (mem_ack) begin
          state_d     = ST_RESP;
          resp_data_d = is_store_q ? 32'h0 : load_data;
`ifdef LSU_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d      = ST_RESP;
          resp_data_d  = 32'h0;
          resp_fault_d = 1'b1;
          resp_cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Bus wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// accesses, all checked against a behavioural model of the RV32I LSU rules.
module tb_load_store_unit;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic [1:0]  resp_cause;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .resp_cause (resp_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [1:0] model_cause(input logic st, input logic [2:0] f3,
                                             input logic [31:0] a);
    bit illegal;
    if (st) illegal = (f3 >= 3);
    else    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
    if (illegal) return 2'd2;
    if ((a % acc_bytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [2:0] f3);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    v = 32'h0;
    case (f3)
      3'd0: begin v = (rd >> (8 * off)) & 32'hFF;   if (v >= 128)   v = v - 256; end
      3'd1: begin v = (rd >> (16 * (off / 2))) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd2: v = rd;
      3'd4: v = (rd >> (8 * off)) & 32'hFF;
      3'd5: v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_sdata(input logic [31:0] wd, input logic [2:0] f3);
    if (f3 == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_strb(input logic [31:0] a, input logic [2:0] f3);
    int unsigned off;
    off = a % 4;
    if (f3 == 0) return 32'(1 << off);
    if (f3 == 1) return 32'(3 << off);
    return 32'hF;
  endfunction

  // One access from an IDLE negedge to the following IDLE negedge.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
    logic [1:0]  cause;
    logic [31:0] exp_data;
    cause    = model_cause(st, f3, a);
    exp_data = st ? 32'h0 : model_load(rd, a, f3);
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; addr = $urandom; wdata = $urandom;
    if (cause != 2'd0) begin
      check("fault_no_bus", 32'(mem_req), 32'd0);
      check("fault_valid", 32'(resp_valid), 32'd1);
      check("fault_flag", 32'(resp_fault), 32'd1);
      check("fault_cause", 32'(resp_cause), 32'(cause));
      check("fault_data", resp_data, 32'h0);
      mem_ack = 1'b1;  // stray ack outside BUS must be ignored
      @(negedge clk);
      mem_ack = 1'b0;
    end else begin
      for (int i = 0; i <= wait_n; i++) begin
        check("bus_req", 32'(mem_req), 32'd1);
        check("bus_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("bus_we", 32'(mem_we), 32'(st));
        check("bus_strb", 32'(mem_wstrb), st ? model_strb(a, f3) : 32'h0);
        if (st) check("bus_wdata", mem_wdata, model_sdata(wd, f3));
        check("bus_no_resp", 32'(resp_valid), 32'd0);
        if (i == wait_n) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_fault", 32'(resp_fault), 32'd0);
      check("resp_cause", 32'(resp_cause), 32'd0);
      check("resp_data", resp_data, exp_data);
      check("resp_bus_idle", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    check("resp_once", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    $display("txn %0d st=%0d f3=%0d addr=%h wdata=%h rdata=%h wait=%0d cause=%0d exp_data=%h",
             txn, st, f3, a, wd, rd, wait_n, cause, exp_data);
    txn++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_resp_cause", 32'(resp_cause), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while the bus request is outstanding
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    check("midbus_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midbus_drop", 32'(mem_req), 32'd0);
    check("midbus_ready", 32'(req_ready), 32'd1);
    check("midbus_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end
    $display("txn %0d reset mid-BUS LW addr=00000100", txn);
    txn++;

    // Directed cases
    do_access(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 3);  // LB sign
    do_access(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1);  // SH upper
    do_access(1'b0, 3'd2, 32'h0000_3001, 32'h0, 32'h0, 0);          // LW misaligned
    do_access(1'b0, 3'd3, 32'h0000_3000, 32'h0, 32'h0, 0);          // illegal load
    do_access(1'b1, 3'd3, 32'h0000_3001, 32'h0, 32'h0, 0);          // illegal beats misaligned
    do_access(1'b0, 3'd5, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 0);  // LHU same-cycle ack
    do_access(1'b0, 3'd2, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 0);  // back-to-back LW
    do_access(1'b1, 3'd0, 32'h0000_5001, 32'h0000_00A5, 32'h0, 2);  // SB lane 1
    do_access(1'b1, 3'd2, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0, 0);  // SW
    do_access(1'b0, 3'd1, 32'h0000_7002, 32'h0, 32'h8001_7FFF, 1);  // LH sign
    do_access(1'b0, 3'd4, 32'h0000_7003, 32'h0, 32'hF100_0000, 0);  // LBU zero-ext
    do_access(1'b1, 3'd1, 32'h0000_7001, 32'h0, 32'h0, 0);          // SH misaligned

    // Random accesses
    for (int n = 0; n < 40; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      a  = $urandom;
      if ($urandom % 3 != 0) a = a & 32'hFFFF_FFFC;
      do_access(st, f3, a, $urandom, $urandom, int'($urandom % 4));
    end

`ifdef LSU_TIMEOUT_EN
    // Bus never acks: expect timeout fault after TB_TIMEOUT BUS cycles
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_8000;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
      check("to_bus_req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    check("to_req_drop", 32'(mem_req), 32'd0);
    check("to_valid", 32'(resp_valid), 32'd1);
    check("to_fault", 32'(resp_fault), 32'd1);
    check("to_cause", 32'(resp_cause), 32'd3);
    check("to_data", resp_data, 32'h0);
    @(negedge clk);
    check("to_resp_once", 32'(resp_valid), 32'd0);
    $display("txn %0d timeout LW addr=00008000", txn);
    txn++;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
